// File: rtl/second_bit_index_buf_if.sv
// Handshake bundle for second_bit_index_buf: upstream one-hot vector in, encoded head entry out.
// slave = the buffer itself, master = the environment driving and consuming it.
interface second_bit_index_buf_if #(
  parameter int WIDTH = 12
);
  localparam int IDXW = $clog2(WIDTH);

  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] onehot_i;
  logic             valid_o;
  logic             ready_i;
  logic [IDXW-1:0]  idx_o;
  logic             none_o;
  logic             err_o;

  modport slave (
    input  valid_i, onehot_i, ready_i,
    output ready_o, valid_o, idx_o, none_o, err_o
  );

  modport master (
    output valid_i, onehot_i, ready_i,
    input  ready_o, valid_o, idx_o, none_o, err_o
  );
endinterface

// File: rtl/second_bit_index_buf.sv
// Two-entry FIFO that encodes each pushed one-hot vector into {index, none, err} at push time.
// Define SECOND_BIT_IDX_ONEHOT_CHECK_EN to build the multi-hot detector; otherwise err_o is tied low.
module second_bit_index_buf #(
  parameter int WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  second_bit_index_buf_if.slave bus
);
  localparam int IDXW = $clog2(WIDTH);

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic            none;
    logic            err;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  entry_t          head_q, head_d;
  entry_t          tail_q, tail_d;
  entry_t          enc;
  logic [IDXW-1:0] low_idx;
  logic            multi_hot;
  logic            push;
  logic            pop;

  // Scan from the top so the last hit, i.e. the lowest set bit, wins.
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (bus.onehot_i[i]) begin
        low_idx = IDXW'(i);
      end
    end
  end

`ifdef SECOND_BIT_IDX_ONEHOT_CHECK_EN
  assign multi_hot = |(bus.onehot_i & (bus.onehot_i - WIDTH'(1)));
`else
  assign multi_hot = 1'b0;
`endif

  assign enc.idx  = low_idx;
  assign enc.none = ~|bus.onehot_i;
  assign enc.err  = multi_hot;

  // Handshake flags come from registered state only, so ready_o never depends on ready_i.
  assign bus.ready_o = (state_q != FULL);
  assign bus.valid_o = (state_q != EMPTY);
  assign push        = bus.valid_i && bus.ready_o;
  assign pop         = bus.valid_o && bus.ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = enc;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = enc;
        end else if (push) begin
          tail_d  = enc;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Outputs are masked when empty so stale entries never leak out.
  assign bus.idx_o  = bus.valid_o ? head_q.idx : '0;
  assign bus.none_o = bus.valid_o & head_q.none;
  assign bus.err_o  = bus.valid_o & head_q.err;
endmodule

// File: tb/tb_second_bit_index_buf.sv
// Self-checking bench for second_bit_index_buf: vector table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_second_bit_index_buf;
  localparam int WIDTH = 12;
`ifdef SECOND_BIT_IDX_ONEHOT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] v;
    int               idx;
    bit               none;
    bit               err;
  } vec_t;

  typedef struct {
    int idx;
    bit none;
    bit err;
  } ref_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  second_bit_index_buf_if #(.WIDTH(WIDTH)) bus ();

  second_bit_index_buf #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_one(input logic [WIDTH-1:0] v, input logic rdy);
    bus.valid_i  = 1'b1;
    bus.onehot_i = v;
    bus.ready_i  = rdy;
    cyc();
    bus.valid_i  = 1'b0;
  endtask

  // Reference encoding from arithmetic: isolate the lowest set bit, take its log2.
  function automatic ref_t ref_enc(input logic [WIDTH-1:0] v);
    ref_t r;
    logic [WIDTH-1:0] low;
    low    = v & (~v + WIDTH'(1));
    r.none = (v == '0);
    r.idx  = (v == '0) ? 0 : $clog2(low);
    r.err  = CHK && ($countones(v) > 1);
    return r;
  endfunction

  vec_t tbl[7];
  ref_t q[$];

  initial begin
    tbl[0] = '{12'b0000_0000_0100, 2, 1'b0, 1'b0};
    tbl[1] = '{12'b0000_0000_0000, 0, 1'b1, 1'b0};
    tbl[2] = '{12'b0000_1010_0000, 5, 1'b0, 1'b1};
    tbl[3] = '{12'b1000_0000_0000, 11, 1'b0, 1'b0};
    tbl[4] = '{12'b0000_0000_0001, 0, 1'b0, 1'b0};
    tbl[5] = '{12'b1111_1111_1111, 0, 1'b0, 1'b1};
    tbl[6] = '{12'b0011_0000_0000, 8, 1'b0, 1'b1};

    bus.valid_i  = 1'b1;
    bus.ready_i  = 1'b0;
    bus.onehot_i = 12'h004;
    repeat (2) @(negedge clk);
    // Reset state, with a push attempt held during reset
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_idx", bus.idx_o, 0);
    chk("rst_none", bus.none_o, 0);
    chk("rst_err", bus.err_o, 0);
    bus.valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Basic push, 1-cycle latency, then pop
    push_one(12'b0000_0000_0100, 1'b1);
    chk("lat_valid", bus.valid_o, 1);
    chk("lat_idx", bus.idx_o, 2);
    chk("lat_none", bus.none_o, 0);
    chk("lat_err", bus.err_o, 0);
    cyc();
    chk("lat_pop_valid", bus.valid_o, 0);
    $display("txn basic push idx=2 popped");

    // Fill, ignored third push, ordered drain
    bus.ready_i = 1'b0;
    push_one(12'b0100_0000_0000, 1'b0);
    push_one(12'b0000_0000_0010, 1'b0);
    chk("full_ready", bus.ready_o, 0);
    bus.valid_i  = 1'b1;
    bus.onehot_i = 12'b0000_0000_0001;
    cyc();
    bus.valid_i = 1'b0;
    chk("full_ign_ready", bus.ready_o, 0);
    chk("full_head_idx", bus.idx_o, 10);
    bus.ready_i = 1'b1;
    cyc();
    chk("drain2_valid", bus.valid_o, 1);
    chk("drain2_idx", bus.idx_o, 1);
    cyc();
    chk("drain_empty", bus.valid_o, 0);
    bus.ready_i = 1'b0;
    $display("txn full drain idx=10 then idx=1");

    // Table-driven encoding checks
    for (int i = 0; i < 7; i++) begin
      push_one(tbl[i].v, 1'b0);
      chk($sformatf("tbl%0d_valid", i), bus.valid_o, 1);
      chk($sformatf("tbl%0d_idx", i), bus.idx_o, tbl[i].idx);
      chk($sformatf("tbl%0d_none", i), bus.none_o, tbl[i].none);
      chk($sformatf("tbl%0d_err", i), bus.err_o, tbl[i].err & CHK);
      cyc();
      chk($sformatf("tbl%0d_stable", i), bus.idx_o, tbl[i].idx);
      bus.ready_i = 1'b1;
      cyc();
      chk($sformatf("tbl%0d_pop", i), bus.valid_o, 0);
      bus.ready_i = 1'b0;
      $display("txn vector=%03h idx=%0d none=%0d err=%0d", tbl[i].v, tbl[i].idx, tbl[i].none, tbl[i].err & CHK);
    end

    // Streaming in ONE: simultaneous push and pop for 8 cycles
    push_one(12'h001, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      bus.valid_i  = 1'b1;
      bus.onehot_i = 12'(1) << k;
      bus.ready_i  = 1'b1;
      chk($sformatf("stream%0d_ready", k), bus.ready_o, 1);
      chk($sformatf("stream%0d_idx", k), bus.idx_o, k - 1);
      cyc();
      $display("txn stream push idx=%0d pop idx=%0d", k, k - 1);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    chk("stream_end_valid", bus.valid_o, 1);
    chk("stream_end_ready", bus.ready_o, 1);
    chk("stream_end_idx", bus.idx_o, 8);
    bus.ready_i = 1'b1;
    cyc();
    chk("stream_end_pop", bus.valid_o, 0);
    bus.ready_i = 1'b0;

    // Asynchronous reset while FULL
    push_one(12'h010, 1'b0);
    push_one(12'h020, 1'b0);
    chk("arst_pre_ready", bus.ready_o, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.valid_o, 0);
    chk("arst_ready", bus.ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    push_one(12'h040, 1'b0);
    chk("arst_after_valid", bus.valid_o, 1);
    chk("arst_after_idx", bus.idx_o, 6);
    bus.ready_i = 1'b1;
    cyc();
    chk("arst_after_pop", bus.valid_o, 0);
    $display("txn async reset recovered idx=6");

    // Randomized run against the queue model
    q.delete();
    for (int n = 0; n < 400; n++) begin
      logic [WIDTH-1:0] v;
      bit psh, pp;
      ref_t r;
      case ($urandom_range(3))
        0:       v = '0;
        3:       v = WIDTH'($urandom);
        default: v = WIDTH'(1) << $urandom_range(WIDTH - 1);
      endcase
      bus.valid_i  = 1'($urandom_range(1));
      bus.ready_i  = 1'($urandom_range(1));
      bus.onehot_i = v;
      #1;
      chk("rnd_ready", bus.ready_o, int'(q.size() < 2));
      chk("rnd_valid", bus.valid_o, int'(q.size() > 0));
      if (q.size() > 0) begin
        chk("rnd_idx", bus.idx_o, q[0].idx);
        chk("rnd_none", bus.none_o, q[0].none);
        chk("rnd_err", bus.err_o, q[0].err);
      end
      psh = bus.valid_i && (q.size() < 2);
      pp  = bus.ready_i && (q.size() > 0);
      @(posedge clk);
      if (pp) begin
        r = q.pop_front();
        $display("txn rnd pop idx=%0d none=%0d err=%0d", r.idx, r.none, r.err);
      end
      if (psh) q.push_back(ref_enc(v));
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/second_bit_index_buf.md
SECOND_BIT_INDEX_BUF -- requirements
Module: second_bit_index_buf

Interface
REQ-001 Parameter WIDTH, default 12, is the width of the one-hot vector received from the second-set-bit stage.
REQ-002 Derived parameter IDXW, value $clog2(WIDTH), is the index width and is not user-overridable.
REQ-003 clk_i  input  1  the single clock; all state SHALL be updated on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 valid_i  input  1  upstream vector on onehot_i is valid.
REQ-006 ready_o  output  1  block can accept a vector this cycle.
REQ-007 onehot_i  input  WIDTH  one-hot (or zero) vector from the second-set-bit stage.
REQ-008 valid_o  output  1  the entry at the head of the buffer is valid.
REQ-009 ready_i  input  1  downstream accepts the head entry.
REQ-010 idx_o  output  IDXW  binary index of the set bit in the head entry.
REQ-011 none_o  output  1  the head entry came from an all-zero vector.
REQ-012 err_o  output  1  the head entry came from a multi-hot vector.

Function
REQ-013 A push SHALL occur when valid_i && ready_o, and a pop SHALL occur when valid_o && ready_i.
REQ-014 The block SHALL be a 2-entry FIFO with states EMPTY, ONE and FULL.
REQ-015 State transitions: push only -> EMPTY->ONE, ONE->FULL; pop only -> FULL->ONE, ONE->EMPTY; push and pop together -> no state change.
REQ-016 ready_o SHALL be 1 in EMPTY and ONE and 0 in FULL, decoded from registered state only, with no combinational path from ready_i.
REQ-017 valid_o SHALL be 1 in ONE and FULL, and 0 in EMPTY.
REQ-018 Latency SHALL be 1 cycle: a vector pushed in cycle N while EMPTY appears on the outputs in cycle N+1, and there is no same-cycle bypass.
REQ-019 Encoding, computed at push: idx_o is the position of the lowest set bit; none_o = (onehot_i == 0) with idx_o = 0; err_o = (more than one bit set).
REQ-020 Entries SHALL leave in arrival order, including under a simultaneous push and pop in ONE.
REQ-021 While valid_o && !ready_i, valid_o, idx_o, none_o and err_o SHALL hold stable.
REQ-022 A push attempted in FULL (valid_i=1, ready_o=0) SHALL be ignored, and the upstream holds the vector.
REQ-023 A pop of an EMPTY buffer cannot occur, because valid_o=0; ready_i SHALL be ignored in EMPTY.
REQ-024 onehot_i SHALL be sampled only on a push, so its value in other cycles has no effect.

Reset
REQ-025 While rst_ni=0 the state SHALL be EMPTY, valid_o=0, idx_o=0, none_o=0, err_o=0 and ready_o=1, and no push SHALL be captured.
REQ-026 Asserting reset mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-027 Deassertion of reset SHALL be synchronized by the integrating level; the first push can occur on the first rising edge with rst_ni=1.

Configuration
REQ-028 Macro SECOND_BIT_IDX_ONEHOT_CHECK_EN: when defined, the multi-hot detector is built and err_o is produced per REQ-019.
REQ-029 When SECOND_BIT_IDX_ONEHOT_CHECK_EN is undefined, no detector logic SHALL exist, err_o SHALL be tied to 0, and all other behaviour is unchanged.

Verification (WIDTH=12, macro defined unless stated)
REQ-030 Reset, then push 12'b0000_0000_0100 with ready_i=1 -> next cycle valid_o=1, idx_o=2, none_o=0, err_o=0; following cycle valid_o=0.
REQ-031 ready_i=0, push 12'b0100_0000_0000 then 12'b0000_0000_0010 -> ready_o=0 after the second push, and a third valid_i is ignored; then raise ready_i -> idx_o=10 then idx_o=1, in order.
REQ-032 Push 12'b0000_0000_0000 -> valid_o=1, none_o=1, idx_o=0, err_o=0.
REQ-033 Push 12'b0000_1010_0000 -> idx_o=5, err_o=1; with the macro undefined -> idx_o=5, err_o=0.
REQ-034 In ONE, push and pop in the same cycle for 8 consecutive cycles with incrementing one-hot inputs -> state stays ONE, ready_o stays 1, and indices emerge in order with 1-cycle latency.
REQ-035 In FULL, pulse rst_ni low mid-cycle -> valid_o falls to 0 and ready_o rises to 1 immediately; after release, the first push is returned correctly.
